// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Handles stall/flush from the hazard unit and branch/jump redirects resolved in ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_pc_next;
  logic        w_squash;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_jump_target   = {r_if_id_pc4[31:28], jump_index, 2'b00};
  assign w_branch_target = {branch_target[31:2], 2'b00};
  // Any redirect makes the word fetched this cycle wrong-path, so it is squashed.
  assign w_squash        = flush | branch_taken | jump;

  // Redirects take priority over a stall.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (branch_taken) begin
      w_pc_next = w_branch_target;
    end else if (jump) begin
      w_pc_next = w_jump_target;
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_if_id_pc4   <= 32'd0;
      r_if_id_instr <= NOP_WORD;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
      if (w_squash) begin
        r_if_id_instr <= NOP_WORD;
        r_if_id_valid <= 1'b0;
        r_if_id_pc4   <= w_pc_plus4;
      end else if (!stall) begin
        r_if_id_instr <= instruction;
        r_if_id_valid <= 1'b1;
        r_if_id_pc4   <= w_pc_plus4;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign pc          = r_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

endmodule
